mem_responder: RTL and testbench

Memory-side responder for the core's unified-bus memory protocol. It holds a 256 x 8 program/data RAM and accepts one request at a time. In the address cycle it latches the address from the core. For a read, it drives the addressed byte back onto the bus in the data cycle. For a write, it captures the byte the core drives in the data cycle. It sits between the core's fetch/execute units and storage, and is the target end of every instruction fetch and operand access.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_array.sv | 23 ++
 rtl/mem_responder.sv | 103 ++++++++++
 tb/tb_mem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and sizes for the unified-bus memory responder.
// Feature macro used by mem_responder: MEM_RSP_WRITE_PROTECT_EN.
package mem_pkg;

   localparam int MEM_DEPTH = 256;
   localparam int BUS_W     = 8;
   localparam int ADDR_W    = $clog2(MEM_DEPTH);
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DATA
   } state_t;

endpackage

// File: rtl/mem_array.sv
// 256 x 8 storage: synchronous write port, combinational read port.
// Contents are intentionally not reset.
module mem_array
   import mem_pkg::*;
(
   input  logic              CLK,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [BUS_W-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [BUS_W-1:0]  rdata
);

   logic [BUS_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge CLK) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Target end of the core's unified memory bus: IDLE -> WAIT -> DATA.
// Optional write protection below PROT_BASE: MEM_RSP_WRITE_PROTECT_EN.
module mem_responder
   import mem_pkg::*;
#(
   parameter int         WAIT_CYCLES = 0,
   parameter logic [7:0] PROT_BASE   = 8'h10
)
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             req,
   input  logic             req_write,
   input  logic [BUS_W-1:0] bus_in,
   output logic [BUS_W-1:0] bus_out,
   output logic             bus_oe,
   output logic             rsp_valid,
   output logic             busy,
   output logic             err
);

   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [ADDR_W-1:0] rd_addr;
   logic [BUS_W-1:0]  rd_data;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              wr, wr_nxt;
   logic              load_rd;
   logic              prot;
   logic              we;

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      wr_nxt    = wr;
      cnt_nxt   = cnt;
      rd_addr   = addr;
      unique case (state)
         S_IDLE: begin
            if (req) begin
               addr_nxt  = bus_in;
               wr_nxt    = req_write;
               cnt_nxt   = WAIT_LD;
               // zero-wait reads must look up the address still on the bus
               rd_addr   = bus_in;
               state_nxt = (WAIT_LD != '0) ? S_WAIT : S_DATA;
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - 1'b1;
            if (cnt == CNT_W'(1))
               state_nxt = S_DATA;
         end
         S_DATA:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign load_rd = (state_nxt == S_DATA) && (state != S_DATA) && !wr_nxt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= S_IDLE;
         addr    <= '0;
         wr      <= 1'b0;
         cnt     <= '0;
         bus_out <= '0;
      end else begin
         state <= state_nxt;
         addr  <= addr_nxt;
         wr    <= wr_nxt;
         cnt   <= cnt_nxt;
         if (load_rd)
            bus_out <= rd_data;
      end
   end

`ifdef MEM_RSP_WRITE_PROTECT_EN
   assign prot = wr && (addr < PROT_BASE);
`else
   logic unused_prot_base;
   assign unused_prot_base = ^PROT_BASE;
   assign prot = 1'b0;
`endif

   assign rsp_valid = (state == S_DATA);
   assign busy      = (state != S_IDLE);
   assign bus_oe    = rsp_valid && !wr;
   assign err       = rsp_valid && prot;
   assign we        = rsp_valid && wr && !prot;

   mem_array u_mem (
      .CLK   (CLK),
      .we    (we),
      .waddr (addr),
      .wdata (bus_in),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a zero-wait and a three-wait instance,
// each checked against a per-instance byte-array memory model.
module tb_mem_responder;

   localparam logic [7:0] PROT = 8'h10;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       req       [2];
   logic       req_write [2];
   logic [7:0] bus_in    [2];
   logic [7:0] bus_out   [2];
   logic       bus_oe    [2];
   logic       rsp_valid [2];
   logic       busy      [2];
   logic       err       [2];

   int checks = 0;
   int errors = 0;

   logic [7:0] model [2][256];
   bit         known [2][256];
   int         wcy   [2] = '{0, 3};

   always #5 CLK = ~CLK;

   mem_responder #(.WAIT_CYCLES(0)) u0 (
      .CLK       (CLK),
      .RST       (RST),
      .req       (req[0]),
      .req_write (req_write[0]),
      .bus_in    (bus_in[0]),
      .bus_out   (bus_out[0]),
      .bus_oe    (bus_oe[0]),
      .rsp_valid (rsp_valid[0]),
      .busy      (busy[0]),
      .err       (err[0])
   );

   mem_responder #(.WAIT_CYCLES(3)) u3 (
      .CLK       (CLK),
      .RST       (RST),
      .req       (req[1]),
      .req_write (req_write[1]),
      .bus_in    (bus_in[1]),
      .bus_out   (bus_out[1]),
      .bus_oe    (bus_oe[1]),
      .rsp_valid (rsp_valid[1]),
      .busy      (busy[1]),
      .err       (err[1])
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit prot_hit(input logic [7:0] a);
`ifdef MEM_RSP_WRITE_PROTECT_EN
      return a < PROT;
`else
      return (a != a);
`endif
   endfunction

   task automatic chk_reset(input int d);
      chk("rst_bus_out", bus_out[d], 8'h00);
      chk("rst_oe", 8'(bus_oe[d]), 8'd0);
      chk("rst_valid", 8'(rsp_valid[d]), 8'd0);
      chk("rst_busy", 8'(busy[d]), 8'd0);
      chk("rst_err", 8'(err[d]), 8'd0);
   endtask

   // one full transaction; checks every cycle from request to release
   task automatic xact(input int d, input bit w, input logic [7:0] a,
                       input logic [7:0] wd);
      @(negedge CLK);
      req[d] = 1'b1;
      req_write[d] = w;
      bus_in[d] = a;
      @(posedge CLK);
      #1;
      req[d] = 1'b0;
      req_write[d] = 1'b0;
      bus_in[d] = 8'h00;
      for (int i = 0; i < wcy[d]; i++) begin
         chk("wait_busy", 8'(busy[d]), 8'd1);
         chk("wait_valid", 8'(rsp_valid[d]), 8'd0);
         chk("wait_oe", 8'(bus_oe[d]), 8'd0);
         @(posedge CLK);
         #1;
      end
      if (w)
         bus_in[d] = wd;
      chk("data_valid", 8'(rsp_valid[d]), 8'd1);
      chk("data_busy", 8'(busy[d]), 8'd1);
      chk("data_oe", 8'(bus_oe[d]), 8'(!w));
      chk("data_err", 8'(err[d]), 8'(w && prot_hit(a)));
      if (!w && known[d][a])
         chk("rd_data", bus_out[d], model[d][a]);
      @(posedge CLK);
      #1;
      bus_in[d] = 8'h00;
      chk("idle_busy", 8'(busy[d]), 8'd0);
      chk("idle_valid", 8'(rsp_valid[d]), 8'd0);
      chk("idle_oe", 8'(bus_oe[d]), 8'd0);
      if (w && !prot_hit(a)) begin
         model[d][a] = wd;
         known[d][a] = 1'b1;
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0;
         req_write[d] = 1'b0;
         bus_in[d] = 8'h00;
         for (int a = 0; a < 256; a++)
            known[d][a] = 1'b0;
      end

      #12;
      chk_reset(0);
      chk_reset(1);
      @(negedge CLK);
      RST = 1'b1;

      // give every location a known value
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 256; a++)
            xact(d, 1'b1, 8'(a), 8'($urandom));

      // write A5 to 20, read back on both instances
      for (int d = 0; d < 2; d++) begin
         xact(d, 1'b1, 8'h20, 8'hA5);
         xact(d, 1'b0, 8'h20, 8'h00);
      end

      // request raised during DATA of a read of FF must be ignored
      @(negedge CLK);
      req[0] = 1'b1;
      req_write[0] = 1'b0;
      bus_in[0] = 8'hFF;
      @(posedge CLK);
      #1;
      req[0] = 1'b1;
      req_write[0] = 1'b1;
      bus_in[0] = 8'h55;
      chk("ign_data_oe", 8'(bus_oe[0]), 8'd1);
      chk("ign_data", bus_out[0], model[0][8'hFF]);
      @(posedge CLK);
      #1;
      req[0] = 1'b0;
      req_write[0] = 1'b0;
      bus_in[0] = 8'h00;
      chk("ign_busy0", 8'(busy[0]), 8'd0);
      @(posedge CLK);
      #1;
      chk("ign_busy1", 8'(busy[0]), 8'd0);
      xact(0, 1'b0, 8'hFF, 8'h00);
      xact(0, 1'b0, 8'h55, 8'h00);

      // low-address write: rejected only when protection is built in
      for (int d = 0; d < 2; d++) begin
         xact(d, 1'b1, 8'h05, 8'h3C);
         xact(d, 1'b0, 8'h05, 8'h00);
      end

      // reset during WAIT of a write of 77 to 40
      @(negedge CLK);
      req[1] = 1'b1;
      req_write[1] = 1'b1;
      bus_in[1] = 8'h40;
      @(posedge CLK);
      #1;
      req[1] = 1'b0;
      req_write[1] = 1'b0;
      bus_in[1] = 8'h77;
      chk("mid_busy", 8'(busy[1]), 8'd1);
      @(posedge CLK);
      #1;
      #3;
      RST = 1'b0;
      #1;
      chk_reset(1);
      bus_in[1] = 8'h00;
      @(negedge CLK);
      RST = 1'b1;
      xact(1, 1'b0, 8'h40, 8'h00);

      // read/write/read over the address extremes
      for (int d = 0; d < 2; d++) begin
         logic [7:0] addrs [3];
         addrs = '{8'h00, 8'hFF, 8'h80};
         for (int i = 0; i < 3; i++) begin
            xact(d, 1'b0, addrs[i], 8'h00);
            xact(d, 1'b1, addrs[i], 8'($urandom));
            xact(d, 1'b0, addrs[i], 8'h00);
         end
      end

      // random traffic
      for (int n = 0; n < 80; n++)
         xact($urandom_range(0, 1), 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
